// File: rtl/req_arbiter.sv
// req_arbiter: registered NUM_REQ-way arbiter with hold limit, preemption and per-requester re-arm mask.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin winner selection (default is fixed priority).
module req_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id,
  output logic               timeout
);

  localparam int               CNT_W     = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   hold_cnt, hold_nxt;
  logic [NUM_REQ-1:0] mask, mask_nxt, elig, grant_nxt;
  logic [ID_W-1:0]    last_id, last_nxt, grant_id_nxt, win;
  logic               timeout_nxt, start, keep, preempt, owner_req;

`ifdef ARB_ROUND_ROBIN_EN
  // Scan downward from last_id-1, wrapping; last_id itself is checked last.
  function automatic logic [ID_W-1:0] pick(input logic [NUM_REQ-1:0] e,
                                           input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] w;
    logic            found;
    int              idx;
    w     = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + NUM_REQ - k) % NUM_REQ;
      if (!found && e[idx]) begin
        w     = ID_W'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction
`else
  function automatic logic [ID_W-1:0] pick(input logic [NUM_REQ-1:0] e);
    logic [ID_W-1:0] w;
    w = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (e[i]) w = ID_W'(i);
    end
    return w;
  endfunction
`endif

  function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [NUM_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  assign elig = req & ~mask;
`ifdef ARB_ROUND_ROBIN_EN
  assign win = pick(elig, last_id);
`else
  assign win = pick(elig);
`endif

  assign start     = enable && (|elig);
  assign owner_req = req[grant_id];
  assign keep      = enable && owner_req && (hold_cnt != HOLD_LAST);
  assign preempt   = enable && owner_req && (hold_cnt == HOLD_LAST);

  // State and output registers; every register here is control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      timeout     <= 1'b0;
      hold_cnt    <= '0;
      mask        <= '0;
      last_id     <= '0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      grant_valid <= |grant_nxt;
      grant_id    <= grant_id_nxt;
      timeout     <= timeout_nxt;
      hold_cnt    <= hold_nxt;
      mask        <= mask_nxt;
      last_id     <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = GRANT;
      GRANT:   if (!keep) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next register values; leaving GRANT by any route clears grant and grant_id.
  always_comb begin
    grant_nxt    = '0;
    grant_id_nxt = '0;
    timeout_nxt  = 1'b0;
    hold_nxt     = '0;
    mask_nxt     = mask & req;
    last_nxt     = last_id;
    case (state)
      IDLE: begin
        if (start) begin
          grant_nxt    = onehot(win);
          grant_id_nxt = win;
          last_nxt     = win;
        end
      end
      GRANT: begin
        if (preempt) begin
          timeout_nxt        = 1'b1;
          mask_nxt[grant_id] = 1'b1;
        end else if (keep) begin
          grant_nxt    = grant;
          grant_id_nxt = grant_id;
          hold_nxt     = hold_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_req_arbiter.sv
// tb_req_arbiter: randomized and directed stimulus against a queue-based scoreboard for req_arbiter.
module tb_req_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int ID_W     = 2;
  localparam int MAX_HOLD = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic [NUM_REQ-1:0] req = '0;
  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;
  logic [ID_W-1:0]    grant_id;
  logic               timeout;

  req_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .enable(enable), .req(req),
    .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_REQ-1:0] g;
    logic               v;
    logic [ID_W-1:0]    id;
    logic               to;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_timeouts = 0;

  // Reference model: owner index (-1 = nobody), cycles owned so far (1-based).
  int                 m_owner = -1;
  int                 m_held  = 0;
  int                 m_last  = 0;
  bit [NUM_REQ-1:0]   m_mask  = '0;

  function automatic int pick_model(input bit [NUM_REQ-1:0] e);
    int w;
    w = -1;
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (m_last - k + NUM_REQ) % NUM_REQ;
      if (w < 0 && e[idx]) w = idx;
    end
`else
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w < 0 && e[i]) w = i;
    end
`endif
    return w;
  endfunction

  task automatic model_step(input bit r, input bit en, input bit [NUM_REQ-1:0] rq);
    exp_t             e;
    bit               to;
    int               w;
    bit [NUM_REQ-1:0] old_mask;
    to = 1'b0;
    if (r) begin
      m_owner = -1;
      m_held  = 0;
      m_mask  = '0;
      m_last  = 0;
    end else begin
      old_mask = m_mask;
      m_mask   = m_mask & rq;
      if (m_owner < 0) begin
        w = pick_model(rq & ~old_mask);
        if (en && w >= 0) begin
          m_owner = w;
          m_held  = 1;
          m_last  = w;
        end
      end else if (!en || !rq[m_owner]) begin
        m_owner = -1;
      end else if (m_held == MAX_HOLD) begin
        to              = 1'b1;
        m_mask[m_owner] = 1'b1;
        m_owner         = -1;
      end else begin
        m_held++;
      end
    end
    e.g  = (m_owner >= 0) ? (NUM_REQ'(1) << m_owner) : '0;
    e.v  = (m_owner >= 0);
    e.id = (m_owner >= 0) ? ID_W'(m_owner) : '0;
    e.to = to;
    q.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit en, input bit [NUM_REQ-1:0] rq);
    @(negedge clk);
    rst    = r;
    enable = en;
    req    = rq;
    model_step(r, en, rq);
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  // Monitor: one registered result per clock, compared after the edge settles.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("grant",       int'(grant),       int'(e.g));
      chk("grant_valid", int'(grant_valid), int'(e.v));
      chk("grant_id",    int'(grant_id),    int'(e.id));
      chk("timeout",     int'(timeout),     int'(e.to));
      if (timeout === 1'b1) n_timeouts++;
    end
  end

  initial begin
    bit [NUM_REQ-1:0] rq;
    bit               en;
    bit               r;
    int               tog;

    repeat (2) cyc(1'b1, 1'b1, 4'b1111);

    repeat (2) cyc(1'b0, 1'b1, 4'b0101);
    repeat (3) cyc(1'b0, 1'b1, 4'b0001);
    cyc(1'b0, 1'b1, 4'b0000);

    repeat (20) cyc(1'b0, 1'b1, 4'b1000);
    repeat (2)  cyc(1'b0, 1'b1, 4'b0000);
    repeat (3)  cyc(1'b0, 1'b1, 4'b1000);
    cyc(1'b0, 1'b1, 4'b0000);

    // Owner drops its request in the same cycle its hold limit is reached.
    repeat (16) cyc(1'b0, 1'b1, 4'b1000);
    repeat (2)  cyc(1'b0, 1'b1, 4'b0000);

    repeat (12) cyc(1'b0, 1'b1, 4'b1111);
    cyc(1'b0, 1'b0, 4'b1111);
    repeat (4) cyc(1'b0, 1'b1, 4'b1111);
    cyc(1'b0, 1'b1, 4'b0000);

    repeat (11) cyc(1'b0, 1'b1, 4'b0100);
    cyc(1'b1, 1'b1, 4'b0100);
    repeat (20) cyc(1'b0, 1'b1, 4'b0100);
    cyc(1'b0, 1'b1, 4'b0000);

    rq = '0;
    for (int phase = 0; phase < 6; phase++) begin
      tog = (phase % 3 == 0) ? 4 : ((phase % 3 == 1) ? 16 : 40);
      for (int n = 0; n < 500; n++) begin
        for (int b = 0; b < NUM_REQ; b++) begin
          if ($urandom_range(tog - 1) == 0) rq[b] = ~rq[b];
        end
        en = ($urandom_range(39) != 0);
        r  = ($urandom_range(199) == 0);
        cyc(r, en, rq);
      end
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
